// File: rtl/float_frame_max.sv
// Per-frame maximum/minimum tracker for IEEE-754 single-precision samples.
// Results are published once per FRAME_LEN accepted samples and held until taken.
module float_frame_max #(
    parameter int unsigned FRAME_LEN = 8
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [31:0]                  s_data,
    input  logic                         s_valid,
    output logic                         s_ready,
    output logic [31:0]                  m_max,
    output logic [31:0]                  m_min,
    output logic [$clog2(FRAME_LEN)-1:0] m_max_idx,
    output logic                         m_valid,
    input  logic                         m_ready
);

    localparam int unsigned IW = $clog2(FRAME_LEN);

    typedef enum logic {
        ACCUM = 1'b0,
        HOLD  = 1'b1
    } state_t;

    state_t          state_q, state_d;
    logic [IW-1:0]   cnt_q, cnt_d;
    logic [31:0]     acc_max_q, acc_max_d;
    logic [31:0]     acc_min_q, acc_min_d;
    logic [IW-1:0]   acc_idx_q, acc_idx_d;
    logic [31:0]     m_max_q, m_max_d;
    logic [31:0]     m_min_q, m_min_d;
    logic [IW-1:0]   m_max_idx_q, m_max_idx_d;
    logic            s_ready_q, s_ready_d;
    logic            m_valid_q, m_valid_d;

    logic            accept;
    logic            first;
    logic            last;
    logic            max_upd;
    logic            min_upd;
    logic [31:0]     nxt_max;
    logic [31:0]     nxt_min;
    logic [IW-1:0]   nxt_idx;

    // Strict bit-level float ordering; NaN/Inf fall out of the same rules.
    function automatic logic fgt(input logic [31:0] a, input logic [31:0] b);
        if (a[31] != b[31]) begin
            return !a[31];
        end else if (!a[31]) begin
            return a[30:0] > b[30:0];
        end else begin
            return a[30:0] < b[30:0];
        end
    endfunction

    always_comb begin
        accept  = (state_q == ACCUM) && s_valid;
        first   = (cnt_q == '0);
        last    = (cnt_q == IW'(FRAME_LEN - 1));
        max_upd = first || fgt(s_data, acc_max_q);
        min_upd = first || fgt(acc_min_q, s_data);
        nxt_max = max_upd ? s_data : acc_max_q;
        nxt_min = min_upd ? s_data : acc_min_q;
        nxt_idx = max_upd ? cnt_q  : acc_idx_q;

        state_d     = state_q;
        cnt_d       = cnt_q;
        acc_max_d   = acc_max_q;
        acc_min_d   = acc_min_q;
        acc_idx_d   = acc_idx_q;
        m_max_d     = m_max_q;
        m_min_d     = m_min_q;
        m_max_idx_d = m_max_idx_q;

        if (accept) begin
            acc_max_d = nxt_max;
            acc_min_d = nxt_min;
            acc_idx_d = nxt_idx;
            if (last) begin
                cnt_d       = '0;
                state_d     = HOLD;
                m_max_d     = nxt_max;
                m_min_d     = nxt_min;
                m_max_idx_d = nxt_idx;
            end else begin
                cnt_d = cnt_q + IW'(1);
            end
        end

        if ((state_q == HOLD) && m_valid_q && m_ready) begin
            state_d = ACCUM;
        end

        // Handshake outputs are registered copies of the next state.
        s_ready_d = (state_d == ACCUM);
        m_valid_d = (state_d == HOLD);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ACCUM;
            cnt_q       <= '0;
            acc_max_q   <= '0;
            acc_min_q   <= '0;
            acc_idx_q   <= '0;
            m_max_q     <= '0;
            m_min_q     <= '0;
            m_max_idx_q <= '0;
            s_ready_q   <= 1'b1;
            m_valid_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            acc_max_q   <= acc_max_d;
            acc_min_q   <= acc_min_d;
            acc_idx_q   <= acc_idx_d;
            m_max_q     <= m_max_d;
            m_min_q     <= m_min_d;
            m_max_idx_q <= m_max_idx_d;
            s_ready_q   <= s_ready_d;
            m_valid_q   <= m_valid_d;
        end
    end

    assign s_ready   = s_ready_q;
    assign m_valid   = m_valid_q;
    assign m_max     = m_max_q;
    assign m_min     = m_min_q;
    assign m_max_idx = m_max_idx_q;

endmodule

// File: tb/tb_float_frame_max.sv
// Directed bench for float_frame_max with FRAME_LEN=4.
module tb_float_frame_max;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] s_data;
    logic        s_valid;
    logic        s_ready;
    logic [31:0] m_max;
    logic [31:0] m_min;
    logic [1:0]  m_max_idx;
    logic        m_valid;
    logic        m_ready;

    int n_pass  = 0;
    int n_total = 0;
    int episodes = 0;
    logic mv_prev = 1'b0;

    float_frame_max #(.FRAME_LEN(4)) dut (
        .clk       (clk),
        .reset     (reset),
        .s_data    (s_data),
        .s_valid   (s_valid),
        .s_ready   (s_ready),
        .m_max     (m_max),
        .m_min     (m_min),
        .m_max_idx (m_max_idx),
        .m_valid   (m_valid),
        .m_ready   (m_ready)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (m_valid && !mv_prev) episodes++;
        mv_prev = m_valid;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [31:0] d);
        s_data  = d;
        s_valid = 1'b1;
        tick();
        s_valid = 1'b0;
    endtask

    task automatic take();
        m_ready = 1'b1;
        tick();
        m_ready = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        s_valid = 1'b1;
        s_data = 32'h4120_0000;
        m_ready = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        s_valid = 1'b0;
        m_ready = 1'b0;
        n_total++; if (m_valid !== 1'b0) $display("FAIL reset_m_valid: got %b expected 0", m_valid); else n_pass++;
        n_total++; if (s_ready !== 1'b1) $display("FAIL reset_s_ready: got %b expected 1", s_ready); else n_pass++;
        n_total++; if (m_max !== 32'h0) $display("FAIL reset_m_max: got %h expected 00000000", m_max); else n_pass++;
        n_total++; if (m_min !== 32'h0) $display("FAIL reset_m_min: got %h expected 00000000", m_min); else n_pass++;
        n_total++; if (m_max_idx !== 2'd0) $display("FAIL reset_idx: got %0d expected 0", m_max_idx); else n_pass++;
    endtask

    task automatic test_mixed_signs();
        send(32'h3F80_0000);
        send(32'hC000_0000);
        send(32'h3F00_0000);
        n_total++; if (m_valid !== 1'b0) $display("FAIL mixed_early_valid: got %b expected 0", m_valid); else n_pass++;
        send(32'hBE80_0000);
        n_total++; if (m_valid !== 1'b1) $display("FAIL mixed_valid_latency: got %b expected 1", m_valid); else n_pass++;
        n_total++; if (s_ready !== 1'b0) $display("FAIL mixed_s_ready: got %b expected 0", s_ready); else n_pass++;
        n_total++; if (m_max !== 32'h3F80_0000) $display("FAIL mixed_max: got %h expected 3f800000", m_max); else n_pass++;
        n_total++; if (m_min !== 32'hC000_0000) $display("FAIL mixed_min: got %h expected c0000000", m_min); else n_pass++;
        n_total++; if (m_max_idx !== 2'd0) $display("FAIL mixed_idx: got %0d expected 0", m_max_idx); else n_pass++;
        take();
        n_total++; if (m_valid !== 1'b0) $display("FAIL mixed_taken_valid: got %b expected 0", m_valid); else n_pass++;
        n_total++; if (s_ready !== 1'b1) $display("FAIL mixed_taken_ready: got %b expected 1", s_ready); else n_pass++;
    endtask

    task automatic test_all_negative();
        send(32'hBFC0_0000);
        send(32'hBF40_0000);
        send(32'hC040_0000);
        send(32'hBF40_0000);
        n_total++; if (m_valid !== 1'b1) $display("FAIL neg_valid: got %b expected 1", m_valid); else n_pass++;
        n_total++; if (m_max !== 32'hBF40_0000) $display("FAIL neg_max: got %h expected bf400000", m_max); else n_pass++;
        n_total++; if (m_max_idx !== 2'd1) $display("FAIL neg_idx: got %0d expected 1", m_max_idx); else n_pass++;
        n_total++; if (m_min !== 32'hC040_0000) $display("FAIL neg_min: got %h expected c0400000", m_min); else n_pass++;
        take();
    endtask

    task automatic test_signed_zero();
        send(32'h8000_0000);
        send(32'h0000_0000);
        send(32'h8000_0000);
        send(32'h8000_0000);
        n_total++; if (m_valid !== 1'b1) $display("FAIL zero_valid: got %b expected 1", m_valid); else n_pass++;
        n_total++; if (m_max !== 32'h0000_0000) $display("FAIL zero_max: got %h expected 00000000", m_max); else n_pass++;
        n_total++; if (m_max_idx !== 2'd1) $display("FAIL zero_idx: got %0d expected 1", m_max_idx); else n_pass++;
        n_total++; if (m_min !== 32'h8000_0000) $display("FAIL zero_min: got %h expected 80000000", m_min); else n_pass++;
        take();
    endtask

    task automatic test_backpressure();
        int bad = 0;
        send(32'h4000_0000);
        send(32'h3F80_0000);
        send(32'h4080_0000);
        send(32'h3E00_0000);
        // 2.0, 1.0, 4.0, 0.125 -> max 4.0 @2, min 0.125
        m_ready = 1'b0;
        for (int i = 0; i < 10; i++) begin
            s_valid = 1'b1;
            s_data  = 32'h4200_0000 + i;
            tick();
            if (m_valid !== 1'b1 || s_ready !== 1'b0 || m_max !== 32'h4080_0000 ||
                m_min !== 32'h3E00_0000 || m_max_idx !== 2'd2) bad++;
        end
        s_valid = 1'b0;
        n_total++; if (bad !== 0) $display("FAIL bp_hold_stable: got %0d bad cycles expected 0", bad); else n_pass++;
        take();
        n_total++; if (m_valid !== 1'b0) $display("FAIL bp_release_valid: got %b expected 0", m_valid); else n_pass++;
        n_total++; if (s_ready !== 1'b1) $display("FAIL bp_release_ready: got %b expected 1", s_ready); else n_pass++;
        n_total++; if (m_max !== 32'h4080_0000) $display("FAIL bp_retained_max: got %h expected 40800000", m_max); else n_pass++;
        send(32'h3F80_0000);
        send(32'h4000_0000);
        send(32'h4040_0000);
        n_total++; if (m_valid !== 1'b0) $display("FAIL bp_next_early_valid: got %b expected 0", m_valid); else n_pass++;
        send(32'h3F00_0000);
        n_total++; if (m_valid !== 1'b1) $display("FAIL bp_next_valid: got %b expected 1", m_valid); else n_pass++;
        n_total++; if (m_max !== 32'h4040_0000) $display("FAIL bp_next_max: got %h expected 40400000", m_max); else n_pass++;
        n_total++; if (m_max_idx !== 2'd2) $display("FAIL bp_next_idx: got %0d expected 2", m_max_idx); else n_pass++;
        n_total++; if (m_min !== 32'h3F00_0000) $display("FAIL bp_next_min: got %h expected 3f000000", m_min); else n_pass++;
        take();
    endtask

    task automatic test_mid_reset();
        send(32'h42C8_0000);
        send(32'hC2C8_0000);
        reset   = 1'b1;
        s_valid = 1'b1;
        s_data  = 32'h4700_0000;
        tick();
        reset   = 1'b0;
        s_valid = 1'b0;
        n_total++; if (m_valid !== 1'b0) $display("FAIL mrst_valid: got %b expected 0", m_valid); else n_pass++;
        n_total++; if (m_max !== 32'h0) $display("FAIL mrst_max: got %h expected 00000000", m_max); else n_pass++;
        n_total++; if (m_min !== 32'h0) $display("FAIL mrst_min: got %h expected 00000000", m_min); else n_pass++;
        send(32'h3F00_0000);
        send(32'h3F80_0000);
        send(32'h3E80_0000);
        n_total++; if (m_valid !== 1'b0) $display("FAIL mrst_early_valid: got %b expected 0", m_valid); else n_pass++;
        send(32'h3F40_0000);
        n_total++; if (m_valid !== 1'b1) $display("FAIL mrst_post_valid: got %b expected 1", m_valid); else n_pass++;
        n_total++; if (m_max !== 32'h3F80_0000) $display("FAIL mrst_post_max: got %h expected 3f800000", m_max); else n_pass++;
        n_total++; if (m_max_idx !== 2'd1) $display("FAIL mrst_post_idx: got %0d expected 1", m_max_idx); else n_pass++;
        n_total++; if (m_min !== 32'h3E80_0000) $display("FAIL mrst_post_min: got %h expected 3e800000", m_min); else n_pass++;
        take();
    endtask

    task automatic test_back_to_back();
        logic [31:0] vec [12];
        logic [31:0] exp_max [3];
        logic [31:0] exp_min [3];
        logic [1:0]  exp_idx [3];
        int start_eps;
        vec = '{32'h4040_0000, 32'hBF80_0000, 32'h4040_0000, 32'hC000_0000,
                32'h7F80_0000, 32'h7FC0_0000, 32'hFF80_0000, 32'h0000_0001,
                32'h3E80_0000, 32'h3E80_0000, 32'h3F00_0000, 32'h3F00_0000};
        exp_max = '{32'h4040_0000, 32'h7FC0_0000, 32'h3F00_0000};
        exp_min = '{32'hC000_0000, 32'hFF80_0000, 32'h3E80_0000};
        exp_idx = '{2'd0, 2'd1, 2'd2};
        start_eps = episodes;
        for (int f = 0; f < 3; f++) begin
            for (int i = 0; i < 4; i++) begin
                repeat ($urandom_range(0, 2)) begin
                    s_valid = 1'b0;
                    s_data  = $urandom;
                    tick();
                end
                send(vec[f*4 + i]);
            end
            n_total++; if (m_valid !== 1'b1) $display("FAIL gap_valid_f%0d: got %b expected 1", f, m_valid); else n_pass++;
            repeat ($urandom_range(0, 3)) begin
                s_valid = 1'($urandom_range(0, 1));
                s_data  = $urandom;
                tick();
            end
            s_valid = 1'b0;
            n_total++; if (m_max !== exp_max[f]) $display("FAIL gap_max_f%0d: got %h expected %h", f, m_max, exp_max[f]); else n_pass++;
            n_total++; if (m_min !== exp_min[f]) $display("FAIL gap_min_f%0d: got %h expected %h", f, m_min, exp_min[f]); else n_pass++;
            n_total++; if (m_max_idx !== exp_idx[f]) $display("FAIL gap_idx_f%0d: got %0d expected %0d", f, m_max_idx, exp_idx[f]); else n_pass++;
            take();
        end
        tick();
        n_total++; if (episodes - start_eps !== 3) $display("FAIL gap_episodes: got %0d expected 3", episodes - start_eps); else n_pass++;
    endtask

    initial begin
        reset   = 1'b1;
        s_valid = 1'b0;
        s_data  = '0;
        m_ready = 1'b0;
        test_reset();
        test_mixed_signs();
        test_all_negative();
        test_signed_zero();
        test_backpressure();
        test_mid_reset();
        test_back_to_back();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/float_frame_max.md
FLOAT_FRAME_MAX -- requirements
Module: float_frame_max

Interface
REQ-001 The module SHALL have parameter FRAME_LEN, default 8, giving the number of samples per frame (legal range 2..256).
REQ-002 The module SHALL have port clk, input, 1 bit: the single clock; all state SHALL update on its rising edge.
REQ-003 The module SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-004 The module SHALL have port s_data, input, 32 bits: IEEE-754 single-precision input sample.
REQ-005 The module SHALL have port s_valid, input, 1 bit: s_data is valid.
REQ-006 The module SHALL have port s_ready, output, 1 bit: the block accepts a sample this cycle.
REQ-007 The module SHALL have port m_max, output, 32 bits: the largest sample of the completed frame.
REQ-008 The module SHALL have port m_min, output, 32 bits: the smallest sample of the completed frame.
REQ-009 The module SHALL have port m_max_idx, output, clog2(FRAME_LEN) bits: the zero-based frame position of m_max.
REQ-010 The module SHALL have port m_valid, output, 1 bit: the frame result is valid.
REQ-011 The module SHALL have port m_ready, input, 1 bit: the consumer takes the result.

Function
REQ-012 A sample SHALL be accepted on a cycle only when both s_valid and s_ready are high.
REQ-013 Greater-than SHALL use strict float ordering:
- if the signs differ, the positive operand is greater (+0 > -0);
- if both are positive, compare {exponent, mantissa} as unsigned;
- if both are negative, the smaller {exponent, mantissa} is greater;
- bit-identical operands are not greater.
REQ-014 NaN and Inf SHALL NOT be given special handling; they are ordered by the bit rules of REQ-013.
REQ-015 The FSM SHALL have exactly two states, ACCUM and HOLD; reset SHALL enter ACCUM with the sample counter at 0.
REQ-016 In ACCUM, s_ready SHALL be 1 and m_valid SHALL be 0.
REQ-017 In HOLD, s_ready SHALL be 0, m_valid SHALL be 1, and m_max, m_min and m_max_idx SHALL be held stable.
REQ-018 The first accepted sample of a frame SHALL load both the running max and the running min, and SHALL set the max index to 0.
REQ-019 Each later accepted sample SHALL behave as follows:
- it replaces the running max only if it is greater (REQ-013), and then loads the max index with its position;
- it replaces the running min only if the running min is greater than it.
REQ-020 On ties, the earliest sample SHALL be retained, both for the value and for the index.
REQ-021 The counter SHALL increment per accepted sample; acceptance of sample FRAME_LEN-1 SHALL clear the counter and transition to HOLD.
REQ-022 m_valid SHALL rise on the cycle after the last sample of the frame is accepted (latency 1).
REQ-023 In HOLD, m_valid && m_ready SHALL return the FSM to ACCUM on the next cycle.
REQ-024 HOLD SHALL persist indefinitely while m_ready is low.
REQ-025 m_ready SHALL be ignored in ACCUM, and s_valid SHALL be ignored in HOLD (no sample lost or counted).
REQ-026 When a frame result is taken, m_max, m_min and m_max_idx SHALL retain their last values until the next frame completes.
REQ-027 There SHALL be no combinational path from s_valid to s_ready or from m_ready to m_valid.

Reset
REQ-028 While reset is high at a clock edge, the block SHALL force:
- state = ACCUM, counter = 0;
- m_valid = 0, s_ready = 1 after the edge;
- m_max = m_min = 32'h0000_0000, m_max_idx = 0.
REQ-029 Reset asserted mid-frame or in HOLD SHALL discard the partial or pending result; the next accepted sample SHALL be index 0.
REQ-030 Reset SHALL take priority over any simultaneous handshake.

Verification
REQ-031 The bench SHALL cover mixed signs: FRAME_LEN=4, samples 1.0(3F800000), -2.0(C0000000), 0.5(3F000000), -0.25(BE800000) -> m_max=3F800000, m_min=C0000000, m_max_idx=0, m_valid one cycle after the 4th accept.
REQ-032 The bench SHALL cover all negatives: -1.5(BFC00000), -0.75(BF400000), -3.0(C0400000), -0.75(BF400000) -> m_max=BF400000, m_max_idx=1 (first tie kept), m_min=C0400000.
REQ-033 The bench SHALL cover signed zero: samples 80000000, 00000000, 80000000, 80000000 -> m_max=00000000, m_max_idx=1, m_min=80000000.
REQ-034 The bench SHALL cover backpressure: hold m_ready=0 for 10 cycles after a frame completes while driving s_valid=1 -> s_ready=0, outputs stable, no samples counted; raising m_ready -> ACCUM next cycle, and the next frame starts at index 0.
REQ-035 The bench SHALL cover mid-frame reset: reset after 2 of 4 samples -> m_valid=0 and outputs zero; 4 new samples yield a result built only from post-reset data.
REQ-036 The bench SHALL cover gapped input: s_valid toggling randomly over 3 back-to-back frames -> results match a software reference model, with exactly one m_valid episode per frame.
